// File: rtl/cordic_pkg.sv
// ----------------------------------------------------------------------------
// cordic_pkg
// Shared constants for the CORDIC vectoring pipeline.
//   ATAN_TBL : round(atan(2^-i) * 180/pi * 256) for i = 0..15 (Q8.8 degrees)
//   KINV     : 1/K in Q0.16, removes the CORDIC gain from the final x
//   ANG_MAX  : 45 degrees in Q8.8, upper clamp of the output angle
//   INFO_*   : bit positions inside the 3-bit source info word
// ----------------------------------------------------------------------------
package cordic_pkg;

    localparam logic [15:0] ATAN_TBL [16] = '{
        16'd11520, 16'd6801, 16'd3593, 16'd1824,
        16'd916,   16'd458,  16'd229,  16'd115,
        16'd57,    16'd29,   16'd14,   16'd7,
        16'd4,     16'd2,    16'd1,    16'd0
    };

    localparam int KINV    = 39797;
    localparam int ANG_MAX = 11520;

    localparam int INFO_X_SIGN = 2;
    localparam int INFO_Y_SIGN = 1;
    localparam int INFO_SWAP   = 0;

endpackage

// File: rtl/cordic_vec_stage.sv
// ----------------------------------------------------------------------------
// cordic_vec_stage
// One registered CORDIC vectoring iteration. Rotates (x,y) towards the x axis
// by +/- atan(2^-SHIFT) and accumulates the rotation into z. Side-band
// (info, zero flag, hsync, vsync) is carried through unchanged.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   i_vsync/i_hsync     sync bits in          o_vsync/o_hsync  delayed 1 clk
//   i_x, i_y            signed DW+1 vector    o_x, o_y         rotated vector
//   i_z                 signed 18 angle acc.  o_z              updated angle
//   i_info, i_zero      side-band in          o_info, o_zero   delayed 1 clk
// ----------------------------------------------------------------------------
module cordic_vec_stage #(
    parameter int          DW       = 16,
    parameter int          SHIFT    = 0,
    parameter logic [15:0] ATAN_VAL = 16'd0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_vsync,
    input  logic                i_hsync,
    input  logic signed [DW:0]  i_x,
    input  logic signed [DW:0]  i_y,
    input  logic signed [17:0]  i_z,
    input  logic [2:0]          i_info,
    input  logic                i_zero,
    output logic                o_vsync,
    output logic                o_hsync,
    output logic signed [DW:0]  o_x,
    output logic signed [DW:0]  o_y,
    output logic signed [17:0]  o_z,
    output logic [2:0]          o_info,
    output logic                o_zero
);

    logic signed [DW:0] w_xs;
    logic signed [DW:0] w_ys;
    logic signed [17:0] w_atan;

    logic               r_vsync;
    logic               r_hsync;
    logic signed [DW:0] r_x;
    logic signed [DW:0] r_y;
    logic signed [17:0] r_z;
    logic [2:0]         r_info;
    logic               r_zero;

    assign w_xs   = i_x >>> SHIFT;
    assign w_ys   = i_y >>> SHIFT;
    assign w_atan = $signed({2'b00, ATAN_VAL});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vsync <= 1'b0;
            r_hsync <= 1'b0;
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_info  <= '0;
            r_zero  <= 1'b0;
        end else begin
            r_vsync <= i_vsync;
            r_hsync <= i_hsync;
            r_info  <= i_info;
            r_zero  <= i_zero;
            // Drive y towards zero; both updates use the pre-stage x/y.
            if (!i_y[DW]) begin
                r_x <= i_x + w_ys;
                r_y <= i_y - w_xs;
                r_z <= i_z + w_atan;
            end else begin
                r_x <= i_x - w_ys;
                r_y <= i_y + w_xs;
                r_z <= i_z - w_atan;
            end
        end
    end

    assign o_vsync = r_vsync;
    assign o_hsync = r_hsync;
    assign o_x     = r_x;
    assign o_y     = r_y;
    assign o_z     = r_z;
    assign o_info  = r_info;
    assign o_zero  = r_zero;

endmodule

// File: rtl/cordic_vector_pipe.sv
// ----------------------------------------------------------------------------
// cordic_vector_pipe
// Pipelined CORDIC vectoring core. Takes first-octant vectors (x>=y>=0) and
// returns gain-compensated magnitude and angle (Q8.8 degrees, 0..45 deg),
// one result per clock, latency ITER+1.
// Ports:
//   clk, rst_n             clock, async active-low reset
//   din_vsync, din_hsync   frame / data valid in
//   din_x, din_y           unsigned vector, x>=y, top two bits zero
//   din_info               3-bit source info, travels with the pixel
//   dout_vsync, dout_hsync syncs delayed ITER+1
//   dout_mag               ~sqrt(x^2+y^2), saturating
//   dout_ang               degrees*256, 0..11520
//   dout_info              din_info delayed ITER+1
// Data outputs read zero on any cycle where dout_hsync is low.
// ----------------------------------------------------------------------------
module cordic_vector_pipe
    import cordic_pkg::*;
#(
    parameter int DW   = 16,
    parameter int ITER = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          din_vsync,
    input  logic          din_hsync,
    input  logic [DW-1:0] din_x,
    input  logic [DW-1:0] din_y,
    input  logic [2:0]    din_info,
    output logic          dout_vsync,
    output logic          dout_hsync,
    output logic [DW-1:0] dout_mag,
    output logic [15:0]   dout_ang,
    output logic [2:0]    dout_info
);

    localparam int PW = DW + 18;

    // Index 0 is the combinational capture, index g+1 the output of stage g.
    logic signed [DW:0] w_x    [ITER+1];
    logic signed [DW:0] w_y    [ITER+1];
    logic signed [17:0] w_z    [ITER+1];
    logic [2:0]         w_info [ITER+1];
    logic               w_zero [ITER+1];
    logic               w_hs   [ITER+1];
    logic               w_vs   [ITER+1];

    assign w_x[0]    = $signed({1'b0, din_x});
    assign w_y[0]    = $signed({1'b0, din_y});
    assign w_z[0]    = '0;
    assign w_info[0] = din_info;
    assign w_zero[0] = (din_x == '0);
    assign w_hs[0]   = din_hsync;
    assign w_vs[0]   = din_vsync;

    for (genvar g = 0; g < ITER; g++) begin : g_stage
        cordic_vec_stage #(
            .DW       (DW),
            .SHIFT    (g),
            .ATAN_VAL (ATAN_TBL[g])
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_vsync (w_vs[g]),
            .i_hsync (w_hs[g]),
            .i_x     (w_x[g]),
            .i_y     (w_y[g]),
            .i_z     (w_z[g]),
            .i_info  (w_info[g]),
            .i_zero  (w_zero[g]),
            .o_vsync (w_vs[g+1]),
            .o_hsync (w_hs[g+1]),
            .o_x     (w_x[g+1]),
            .o_y     (w_y[g+1]),
            .o_z     (w_z[g+1]),
            .o_info  (w_info[g+1]),
            .o_zero  (w_zero[g+1])
        );
    end

    // The residual y is only needed inside the chain.
    logic w_unused_y;
    assign w_unused_y = ^w_y[ITER];

    // Gain compensation: round(x_N * KINV / 2^16). x_N is non-negative in
    // vectoring mode; a negative value is treated as zero for safety.
    logic [DW:0]     w_xu;
    logic [PW-1:0]   w_prod;
    logic [PW-1:0]   w_mag_full;
    logic [DW-1:0]   w_mag;
    logic [15:0]     w_ang;

    assign w_xu       = w_x[ITER][DW] ? '0 : w_x[ITER][DW:0];
    assign w_prod     = PW'(w_xu) * PW'(KINV) + PW'(32768);
    assign w_mag_full = w_prod >> 16;

    always_comb begin
        w_mag = w_mag_full[DW-1:0];
        if (|w_mag_full[PW-1:DW]) w_mag = '1;

        w_ang = w_z[ITER][15:0];
        if (w_z[ITER] < 0)
            w_ang = '0;
        else if (w_z[ITER] > $signed(18'(ANG_MAX)))
            w_ang = 16'(ANG_MAX);

        if (w_zero[ITER]) begin
            w_mag = '0;
            w_ang = '0;
        end
    end

    logic          r_vsync;
    logic          r_hsync;
    logic [DW-1:0] r_mag;
    logic [15:0]   r_ang;
    logic [2:0]    r_info;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vsync <= 1'b0;
            r_hsync <= 1'b0;
            r_mag   <= '0;
            r_ang   <= '0;
            r_info  <= '0;
        end else begin
            r_vsync <= w_vs[ITER];
            r_hsync <= w_hs[ITER];
            // Blank data alongside the hsync it travels with.
            if (w_hs[ITER]) begin
                r_mag  <= w_mag;
                r_ang  <= w_ang;
                r_info <= w_info[ITER];
            end else begin
                r_mag  <= '0;
                r_ang  <= '0;
                r_info <= '0;
            end
        end
    end

    assign dout_vsync = r_vsync;
    assign dout_hsync = r_hsync;
    assign dout_mag   = r_mag;
    assign dout_ang   = r_ang;
    assign dout_info  = r_info;

endmodule

// File: tb/tb_cordic_vector_pipe.sv
module tb_cordic_vector_pipe;

    localparam int DW   = 16;
    localparam int ITER = 12;
    localparam int ATAN_T [16] = '{11520, 6801, 3593, 1824, 916, 458, 229, 115,
                                   57, 29, 14, 7, 4, 2, 1, 0};

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          din_vsync = 1'b0;
    logic          din_hsync = 1'b0;
    logic [DW-1:0] din_x = '0;
    logic [DW-1:0] din_y = '0;
    logic [2:0]    din_info = '0;
    logic          dout_vsync;
    logic          dout_hsync;
    logic [DW-1:0] dout_mag;
    logic [15:0]   dout_ang;
    logic [2:0]    dout_info;

    cordic_vector_pipe #(.DW(DW), .ITER(ITER)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din_vsync  (din_vsync),
        .din_hsync  (din_hsync),
        .din_x      (din_x),
        .din_y      (din_y),
        .din_info   (din_info),
        .dout_vsync (dout_vsync),
        .dout_hsync (dout_hsync),
        .dout_mag   (dout_mag),
        .dout_ang   (dout_ang),
        .dout_info  (dout_info)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        vs;
        logic        hs;
        longint      mag;
        longint      ang;
        logic [2:0]  info;
    } exp_t;

    int checks = 0;
    int errors = 0;
    exp_t q[$];
    exp_t cur;
    bit   armed = 0;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %0d required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic chk_tol(input string name, input real act, input real req, input real tol);
        checks++;
        if (act > req + tol || act < req - tol) begin
            errors++;
            $display("FAIL %s actual %0f required %0f +/- %0f", name, act, req, tol);
        end
    endtask

    // Reference: the iteration rules written as a plain integer loop, then
    // compensation, clamps, zero override and hsync blanking.
    function automatic exp_t model(input int x, input int y, input logic [2:0] info,
                                   input logic hs, input logic vs);
        exp_t   e;
        longint xx = x, yy = y, zz = 0, xn, m, a;
        for (int i = 0; i < ITER; i++) begin
            if (yy >= 0) begin
                xn = xx + (yy >>> i); yy = yy - (xx >>> i); zz = zz + ATAN_T[i];
            end else begin
                xn = xx - (yy >>> i); yy = yy + (xx >>> i); zz = zz - ATAN_T[i];
            end
            xx = xn;
        end
        m = (xx * 39797 + 32768) / 65536;
        if (m > 65535) m = 65535;
        a = (zz < 0) ? 0 : (zz > 11520) ? 11520 : zz;
        if (x == 0) begin m = 0; a = 0; end
        e.vs = vs; e.hs = hs;
        e.mag  = hs ? m : 0;
        e.ang  = hs ? a : 0;
        e.info = hs ? info : 3'b000;
        return e;
    endfunction

    // Sanity of the reference against ideal floating-point geometry.
    task automatic pin_float(input int x, input int y);
        exp_t e;
        real  fm, fa;
        e  = model(x, y, 3'b000, 1'b1, 1'b0);
        fm = $sqrt(real'(x) * x + real'(y) * y);
        fa = (x == 0) ? 0.0 : $atan2(real'(y), real'(x)) * 180.0 / 3.14159265358979 * 256.0;
        chk_tol("model_mag_vs_float", real'(e.mag), fm, 12.0);
        chk_tol("model_ang_vs_float", real'(e.ang), fa, 20.0);
    endtask

    // Expected-output queue: entry popped after each edge is the input that
    // was captured ITER edges earlier; reset leaves the pipe full of zeros.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            cur = model(0, 0, 3'b000, 1'b0, 1'b0);
            for (int i = 0; i < ITER; i++) q.push_back(cur);
        end else begin
            q.push_back(model(int'(din_x), int'(din_y), din_info, din_hsync, din_vsync));
            cur = q.pop_front();
        end
    end

    always @(negedge clk) begin
        if (rst_n && armed) begin
            chk("vsync", dout_vsync, cur.vs);
            chk("hsync", dout_hsync, cur.hs);
            chk("mag",   dout_mag,   cur.mag);
            chk("ang",   dout_ang,   cur.ang);
            chk("info",  dout_info,  cur.info);
        end
    end

    task automatic drive(input int x, input int y, input logic [2:0] info,
                         input logic hs, input logic vs);
        @(posedge clk);
        #1;
        din_x = DW'(x); din_y = DW'(y); din_info = info;
        din_hsync = hs; din_vsync = vs;
    endtask

    initial begin
        exp_t e;
        int   x, y;
        logic hs, vs;
        logic [4:0] hpat = 5'b01101;

        // Hand-computed pins of the reference itself.
        e = model(1000, 0, 3'b000, 1'b1, 1'b0);
        chk("pin_1000_0_mag", e.mag, 1001);
        chk("pin_1000_0_ang", e.ang, 11);
        e = model(0, 0, 3'b111, 1'b1, 1'b0);
        chk("pin_zero_mag", e.mag, 0);
        chk("pin_zero_ang", e.ang, 0);
        e = model(4000, 3000, 3'b011, 1'b0, 1'b1);
        chk("pin_gated_mag", e.mag, 0);
        chk("pin_gated_info", e.info, 0);
        pin_float(1000, 0);
        pin_float(1000, 1000);
        pin_float(4000, 3000);
        pin_float(16383, 16383);
        pin_float(16383, 1);

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_vsync", dout_vsync, 0);
        chk("rst_hsync", dout_hsync, 0);
        chk("rst_mag",   dout_mag,   0);
        chk("rst_ang",   dout_ang,   0);
        chk("rst_info",  dout_info,  0);
        rst_n = 1'b1;
        armed = 1;

        // Single pixel: exact latency and literal result.
        drive(1000, 0, 3'b000, 1'b1, 1'b0);
        drive(0, 0, 3'b000, 1'b0, 1'b0);
        repeat (ITER - 1) @(posedge clk);
        #1;
        chk("lat_early_hsync", dout_hsync, 0);
        @(posedge clk);
        #1;
        chk("lat_hsync", dout_hsync, 1);
        chk("lat_mag",   dout_mag,   1001);
        chk("lat_ang",   dout_ang,   11);
        repeat (4) @(posedge clk);

        // Directed boundary vectors back-to-back.
        drive(1000, 1000, 3'b101, 1'b1, 1'b1);
        drive(4000, 3000, 3'b011, 1'b1, 1'b1);
        drive(0, 0, 3'b110, 1'b1, 1'b1);
        drive(16383, 16383, 3'b001, 1'b1, 1'b1);
        drive(16383, 0, 3'b010, 1'b1, 1'b0);
        drive(0, 0, 3'b000, 1'b0, 1'b0);
        repeat (ITER + 3) @(posedge clk);

        // Random stream, hsync 1-0-1-1-0, vsync toggling, reset mid-stream.
        vs = 1'b0;
        for (int k = 0; k < 800; k++) begin
            x = int'($urandom_range(0, 16383));
            y = int'($urandom_range(0, x));
            case ($urandom_range(0, 9))
                0: y = x;
                1: y = 0;
                2: begin x = 0; y = 0; end
                default: ;
            endcase
            hs = hpat[k % 5];
            if (k % 37 == 0) vs = ~vs;
            drive(x, y, 3'($urandom_range(0, 7)), hs, vs);
            if (k == 400) begin
                #3;
                rst_n = 1'b0;
                #1;
                chk("async_rst_vsync", dout_vsync, 0);
                chk("async_rst_hsync", dout_hsync, 0);
                chk("async_rst_mag",   dout_mag,   0);
                chk("async_rst_ang",   dout_ang,   0);
                chk("async_rst_info",  dout_info,  0);
                @(posedge clk);
                #2;
                rst_n = 1'b1;
            end
            if (k % 50 == 0) pin_float(x, y);
        end
        drive(0, 0, 3'b000, 1'b0, 1'b0);
        repeat (ITER + 3) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
